// File: rtl/sram_pkg.sv
// Shared sizing constants and word/address types for the small synchronous SRAM.
// The top module and its word-register sub-module both import this package.
package sram_pkg;
   localparam int SRAM_ADDR_W = 5;
   localparam int SRAM_DATA_W = 6;
   localparam int SRAM_DEPTH  = 2 ** SRAM_ADDR_W;

   typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
   typedef logic [SRAM_DATA_W-1:0] sram_word_t;
endpackage : sram_pkg

// File: rtl/sram_16_word.sv
// One storage word of the SRAM array.
// It has a synchronous clear, a write enable and a data input.
module sram_16_word
   import sram_pkg::*;
#(
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] word_r;

   // Word storage: clear wins over write
   always_ff @(posedge clk) begin
      if (rst) begin
         word_r <= {DATA_W{1'b0}};
      end else if (we) begin
         word_r <= d;
      end else begin
         word_r <= word_r;
      end
   end

   assign q = word_r;

endmodule : sram_16_word

// File: rtl/sram_16.sv
// Single-port synchronous SRAM built from DEPTH word registers.
// It has an address decoder, a DEPTH:1 read mux and a registered read output.
module sram_16
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] Data,
   output logic [DATA_W-1:0] Rout
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0]  we_s;
   logic [DATA_W-1:0] word_s [DEPTH];
   logic [DATA_W-1:0] rd_s;
   logic [DATA_W-1:0] rout_r;

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign we_s[i] = wr & (Addr == ADDR_W'(i));

      sram_16_word #(
         .DATA_W (DATA_W)
      ) u_word (
         .clk (clk),
         .rst (rst),
         .we  (we_s[i]),
         .d   (Data),
         .q   (word_s[i])
      );
   end

   // Read mux selecting the addressed word
   always_comb begin
      rd_s = word_s[Addr];
   end

   // Read register: loads only on read cycles, so it holds through writes
   always_ff @(posedge clk) begin
      if (rst) begin
         rout_r <= {DATA_W{1'b0}};
      end else if (!wr) begin
         rout_r <= rd_s;
      end else begin
         rout_r <= rout_r;
      end
   end

   assign Rout = rout_r;

endmodule : sram_16

// File: tb/tb_sram_16.sv
// Self-checking bench for sram_16: directed scenarios plus randomized traffic.
// The traffic is compared against an array-based reference model.
module tb_sram_16;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr;
   logic [4:0] Addr;
   logic [5:0] Data;
   logic [5:0] Rout;

   int n_cmp = 0;
   int n_bad = 0;

   logic [5:0] ref_mem [32];
   logic [5:0] ref_rout;

   always #5 clk = ~clk;

   sram_16 dut (
      .clk  (clk),
      .rst  (rst),
      .wr   (wr),
      .Addr (Addr),
      .Data (Data),
      .Rout (Rout)
   );

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock edge with the given inputs.
   // The model is updated, then Rout is checked against it just after the edge.
   task automatic cyc(input logic r, input logic w, input logic [4:0] a, input logic [5:0] d);
      rst  = r;
      wr   = w;
      Addr = a;
      Data = d;
      @(posedge clk);
      if (r) begin
         foreach (ref_mem[i]) ref_mem[i] = 6'd0;
         ref_rout = 6'd0;
      end else if (w) begin
         ref_mem[a] = d;
      end else begin
         ref_rout = ref_mem[a];
      end
      #1;
      chk("model", Rout, ref_rout);
   endtask

   initial begin
      rst  = 1'b0;
      wr   = 1'b0;
      Addr = 5'd0;
      Data = 6'd0;
      ref_rout = 6'bx;

      // reset, then reads return zero
      cyc(1'b1, 1'b0, 5'd0, 6'd0);  chk("rst_rout", Rout, 6'b000000);
      cyc(1'b0, 1'b0, 5'd0, 6'd0);  chk("rst_rd0",  Rout, 6'b000000);
      cyc(1'b0, 1'b0, 5'd3, 6'd0);  chk("rst_rd3",  Rout, 6'b000000);
      cyc(1'b0, 1'b0, 5'd31, 6'd0); chk("rst_rd31", Rout, 6'b000000);

      // write then read back
      cyc(1'b0, 1'b1, 5'd3, 6'b101010);
      cyc(1'b0, 1'b1, 5'd5, 6'b010101);
      cyc(1'b0, 1'b1, 5'd7, 6'b111000);
      cyc(1'b0, 1'b0, 5'd3, 6'd0); chk("wr_rd3", Rout, 6'b101010);
      cyc(1'b0, 1'b0, 5'd5, 6'd0); chk("wr_rd5", Rout, 6'b010101);
      cyc(1'b0, 1'b0, 5'd7, 6'd0); chk("wr_rd7", Rout, 6'b111000);

      // Rout holds across a write
      cyc(1'b0, 1'b0, 5'd3, 6'd0);       chk("hold_pre", Rout, 6'b101010);
      cyc(1'b0, 1'b1, 5'd5, 6'b000111);  chk("hold",     Rout, 6'b101010);
      cyc(1'b0, 1'b0, 5'd5, 6'd0);       chk("hold_rd5", Rout, 6'b000111);

      // reset coincident with a write discards the write
      cyc(1'b1, 1'b1, 5'd7, 6'b111111); chk("mid_rst",  Rout, 6'b000000);
      cyc(1'b0, 1'b0, 5'd3, 6'd0);      chk("mid_rd3",  Rout, 6'b000000);
      cyc(1'b0, 1'b0, 5'd5, 6'd0);      chk("mid_rd5",  Rout, 6'b000000);
      cyc(1'b0, 1'b0, 5'd7, 6'd0);      chk("mid_rd7",  Rout, 6'b000000);

      // address extremes
      cyc(1'b0, 1'b1, 5'd0,  6'b000001);
      cyc(1'b0, 1'b1, 5'd31, 6'b100000);
      cyc(1'b0, 1'b0, 5'd31, 6'd0); chk("bnd_rd31", Rout, 6'b100000);
      cyc(1'b0, 1'b0, 5'd0,  6'd0); chk("bnd_rd0",  Rout, 6'b000001);
      cyc(1'b0, 1'b0, 5'd30, 6'd0); chk("bnd_rd30", Rout, 6'b000000);

      // back-to-back write then read
      cyc(1'b0, 1'b1, 5'd12, 6'b110011);
      cyc(1'b0, 1'b0, 5'd12, 6'd0); chk("b2b_rd12", Rout, 6'b110011);

      // randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 31)),
             6'($urandom_range(0, 63)));
      end

      // sweep every address to read back the final contents
      for (int a = 0; a < 32; a++) begin
         cyc(1'b0, 1'b0, 5'(a), 6'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_sram_16
